pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage, replacing the fixed 32-bit PC mux. It owns the PC register, boot through a reset vector word, branch/call redirect, stalls, and a synchronous, single-level interrupt entry and return. Interrupt entry uses a vector-fetch handshake with instruction memory and saves the EPC internally. It feeds `pc_out` to instruction memory and receives redirects from decode/execute.

## Interface
- `ADDR_W`, 32: PC / address width.
- `RESET_VEC`, 32'h20: address loaded on reset; memory word there holds the boot target.
- `INT_VEC`, 0: address driven on interrupt entry; memory word there holds the ISR target.
- `STEP`, 1: sequential increment, in address units.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_enable` in 1: advance enable; low = stall.
- `branch_valid` in 1: redirect request.
- `branch_addr` in ADDR_W: redirect target.
- `rti_valid` in 1: return-from-interrupt request.
- `irq` in 1: interrupt request, level, sampled on `clk`.
- `vector_valid` in 1: memory returns the vector word this cycle.
- `vector_data` in ADDR_W: vector word (next PC).
- `pc_out` out ADDR_W: current PC, registered.
- `vector_req` out 1: high in BOOT and INT_LOAD.
- `irq_ack` out 1: one-cycle pulse on interrupt acceptance.
- `in_isr` out 1: handler active.
- `epc_out` out ADDR_W: saved return address.

## Operation
- States: BOOT, RUN, INT_LOAD.
- Reset: state=BOOT, `pc_out`=RESET_VEC, `epc_out`=0, `in_isr`=0, `irq_ack`=0, pending=0.
- Reset mid-operation (any state, any cycle) aborts everything and returns to the reset values; pending interrupt is discarded.
- BOOT: hold `pc_out`; on `vector_valid`&&`pc_enable`, pc<=`vector_data`, go to RUN.
- RUN, per enabled cycle, priority order:
  - `rti_valid`: pc<=`epc_out`, `in_isr`<=0. If `in_isr`=0, ignore `rti_valid` and fall through.
  - Else if `branch_valid`: target=`branch_addr`.
  - Else: target=pc+STEP, modulo 2^ADDR_W (wraps to 0).
  - If pending&&!`in_isr` and no rti this cycle: epc<=target, pc<=INT_VEC, `irq_ack`=1, `in_isr`<=1, pending<=0, go to INT_LOAD. Otherwise pc<=target.
- INT_LOAD: hold INT_VEC; on `vector_valid`&&`pc_enable`, pc<=`vector_data`, go to RUN.
- Pending latch: set when `irq`=1 on any edge, including stalled cycles, BOOT, INT_LOAD and in-ISR. It clears only on acceptance. No nesting: an irq during the ISR is taken after rti, on the next eligible cycle.
- `branch_valid`/`rti_valid` outside RUN: ignored.
- `vector_valid` in RUN: ignored.

## Timing
- All outputs are registered. `pc_out` changes one cycle after the qualifying edge's inputs.
- Branch/rti/irq latency: target visible on `pc_out` the cycle after the request edge.
- Irq latency: minimum 1 cycle (irq sampled on edge N, accepted on edge N+1 if enabled in RUN).
- `irq_ack` is high for exactly the cycle after acceptance.
- `pc_enable`=0 freezes pc, state, epc and `in_isr`; the pending latch still sets.
- Vector handshake: `vector_req` is level; completes on the first cycle with `vector_valid`&&`pc_enable`. There is no timeout.

## Configuration
- `PC_SEQ_IRQ_EN` defined: interrupt logic as above.
- `PC_SEQ_IRQ_EN` undefined: no pending latch, epc or INT_LOAD state. `irq` and `rti_valid` are ignored; `irq_ack`, `in_isr` and `epc_out` tie to 0. BOOT/RUN/branch/stall behaviour is unchanged.

## Structure
- Shared package `pc_pkg`: state enum (BOOT, RUN, INT_LOAD), state width constant.
- One sub-module `pc_irq_ctrl`: pending latch, `in_isr`, epc register, accept/ack logic. It is instantiated only under `PC_SEQ_IRQ_EN`.

## Test plan
All scenarios use ADDR_W=32, RESET_VEC=0x20, INT_VEC=0, STEP=1.
- Boot: release rst, vector_valid with 0x100 after 3 cycles → pc 0x20 held, then 0x100, 0x101, 0x102.
- Branch + stall: at pc 0x105, branch to 0x200 with pc_enable=0 for 2 cycles → pc stays 0x105; on enable, 0x200.
- Interrupt: irq at pc 0x110 → irq_ack pulse, pc=0, epc=0x111; vector 0x300 → pc 0x300; rti → pc 0x111, in_isr=0.
- Simultaneous branch+irq at pc 0x120, target 0x400 → pc=0, epc=0x400.
- Nested irq during ISR, rti same cycle as irq → pc=epc; next cycle irq accepted with epc=epc+1.
- Wrap and reset: pc 0xFFFFFFFF → 0x0. Assert rst during INT_LOAD → pc 0x20, state BOOT, in_isr=0, pending cleared.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: types and constants shared by the program-counter sequencer files.
//   PC_STATE_W  width of the sequencer state register
//   pc_state_e  state encoding (BOOT, RUN, INT_LOAD)
package pc_pkg;

  localparam int PC_STATE_W = 2;

  typedef enum logic [PC_STATE_W-1:0] {
    PC_BOOT     = 2'd0,
    PC_RUN      = 2'd1,
    PC_INT_LOAD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side bus between the core and the PC sequencer.
//   master: core/memory side (drives enables, redirects, irq, vector word)
//   slave : sequencer side (drives pc_out, vector_req, irq_ack, in_isr, epc_out)
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              pc_enable;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_addr;
  logic              rti_valid;
  logic              irq;
  logic              vector_valid;
  logic [ADDR_W-1:0] vector_data;
  logic [ADDR_W-1:0] pc_out;
  logic              vector_req;
  logic              irq_ack;
  logic              in_isr;
  logic [ADDR_W-1:0] epc_out;

  modport master (
    output pc_enable, branch_valid, branch_addr, rti_valid, irq,
           vector_valid, vector_data,
    input  pc_out, vector_req, irq_ack, in_isr, epc_out
  );

  modport slave (
    input  pc_enable, branch_valid, branch_addr, rti_valid, irq,
           vector_valid, vector_data,
    output pc_out, vector_req, irq_ack, in_isr, epc_out
  );
endinterface

// File: rtl/pc_sequencer_irq_ctrl.sv
// pc_irq_ctrl: single-level interrupt bookkeeping for the PC sequencer.
// Holds the pending latch, the in-ISR flag and the saved return address,
// and decides when an interrupt is accepted or a return is honoured.
//   clk, rst   clock, async active-high reset
//   adv        enabled cycle in RUN (the only cycles that may redirect)
//   irq        level interrupt request
//   rti_valid  return-from-interrupt request
//   target     next sequential/branch PC, saved as EPC on acceptance
//   rti_take   return honoured this cycle (only while in the handler)
//   accept     interrupt accepted this cycle
//   irq_ack    registered one-cycle acceptance pulse
//   in_isr     handler active
//   epc        saved return address
import pc_pkg::*;

module pc_irq_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              irq,
  input  logic              rti_valid,
  input  logic [ADDR_W-1:0] target,
  output logic              rti_take,
  output logic              accept,
  output logic              irq_ack,
  output logic              in_isr,
  output logic [ADDR_W-1:0] epc
);

  logic pending;

  // rti needs in_isr and acceptance needs !in_isr, so the two never coincide.
  assign rti_take = adv && rti_valid && in_isr;
  assign accept   = adv && pending && !in_isr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      in_isr  <= 1'b0;
      irq_ack <= 1'b0;
      epc     <= '0;
    end else begin
      // A still-high irq on the acceptance edge counts as a fresh request.
      pending <= (pending && !accept) || irq;
      irq_ack <= accept;
      if (accept) begin
        epc    <= target;
        in_isr <= 1'b1;
      end else if (rti_take) begin
        in_isr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
// Boots through a reset-vector word, follows branch/call redirects, stalls
// on pc_enable=0 and, when PC_SEQ_IRQ_EN is defined, takes single-level
// interrupts through a vector-word fetch with an internally saved EPC.
//   clk, rst  clock, async active-high reset
//   bus       pc_sequencer_if.slave (enables, redirects, vector handshake,
//             pc_out, irq_ack, in_isr, epc_out)
// Build option: PC_SEQ_IRQ_EN enables the interrupt logic; without it irq
// and rti_valid are ignored and irq_ack/in_isr/epc_out read 0.
//
// state    | meaning
// BOOT     | hold RESET_VEC, wait for the boot target word
// RUN      | sequential fetch, branches, rti, interrupt acceptance
// INT_LOAD | hold INT_VEC, wait for the handler target word
import pc_pkg::*;

module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 'h20,
  parameter logic [ADDR_W-1:0] INT_VEC   = '0,
  parameter int                STEP      = 1
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam logic [PC_STATE_W-1:0] ST_BOOT     = PC_BOOT;
  localparam logic [PC_STATE_W-1:0] ST_RUN      = PC_RUN;
  localparam logic [PC_STATE_W-1:0] ST_INT_LOAD = PC_INT_LOAD;

  logic [PC_STATE_W-1:0] state;
  logic [ADDR_W-1:0]     pc_q;
  logic [ADDR_W-1:0]     target;
  logic [ADDR_W-1:0]     epc;
  logic                  vector_req_q;
  logic                  adv;
  logic                  vec_done;
  logic                  rti_take;
  logic                  accept;
  logic                  irq_ack;
  logic                  in_isr;

  assign adv      = bus.pc_enable && (state == ST_RUN);
  assign vec_done = bus.pc_enable && bus.vector_valid && (state != ST_RUN);
  assign target   = bus.branch_valid ? bus.branch_addr : pc_q + ADDR_W'(STEP);

`ifdef PC_SEQ_IRQ_EN
  pc_irq_ctrl #(.ADDR_W(ADDR_W)) u_irq_ctrl (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .irq       (bus.irq),
    .rti_valid (bus.rti_valid),
    .target    (target),
    .rti_take  (rti_take),
    .accept    (accept),
    .irq_ack   (irq_ack),
    .in_isr    (in_isr),
    .epc       (epc)
  );
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = bus.irq ^ bus.rti_valid;
  assign rti_take = 1'b0;
  assign accept   = 1'b0;
  assign irq_ack  = 1'b0;
  assign in_isr   = 1'b0;
  assign epc      = '0;
`endif

  // vector_req is a flop of its own so it is truly registered, tracking
  // "state != RUN".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BOOT;
      pc_q         <= RESET_VEC;
      vector_req_q <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (adv) begin
            if (rti_take) begin
              pc_q <= epc;
            end else if (accept) begin
              pc_q         <= INT_VEC;
              state        <= ST_INT_LOAD;
              vector_req_q <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end
        end
        default: begin
          // BOOT and INT_LOAD share the vector-word handshake.
          if (vec_done) begin
            pc_q         <= bus.vector_data;
            state        <= ST_RUN;
            vector_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.vector_req = vector_req_q;
  assign bus.irq_ack    = irq_ack;
  assign bus.in_isr     = in_isr;
  assign bus.epc_out    = epc;

endmodule
